// File: rtl/txrx_arq_ctrl.sv
// txrx_arq_ctrl: per-LT_ADDR ARQN/SEQN/FLOW scheduler for the ACL payload buffers
module txrx_arq_ctrl #(
    parameter int NLT = 8,
    parameter int FTW = 16
) (
    input  logic           clk_6M,
    input  logic           rstz,
    input  logic           connsactive,
    input  logic           ms_tslot_p,
    input  logic           dec_hdr_endp,
    input  logic           dec_hecgood,
    input  logic [2:0]     dec_lt_addr,
    input  logic           dec_arqn,
    input  logic           dec_flow,
    input  logic           dec_seqn,
    input  logic           pktype_data,
    input  logic           dec_crc_endp,
    input  logic           dec_crcgood,
    input  logic           regi_aclrxbufempty,
    input  logic           tx_packet_st_p,
    input  logic [2:0]     tx_lt_addr,
    input  logic           tx_pktype_data,
    input  logic           regi_txdatready,
    input  logic [FTW-1:0] regi_flushto,
    input  logic           regi_ltinit_p,
    input  logic [2:0]     regi_ltsel,
    output logic           sendnewpy,
    output logic           tx_seqn,
    output logic           tx_arqn,
    output logic           tx_flow,
    output logic           rxpy_accept_p,
    output logic           rxpy_dup_p,
    output logic           newpy_int_p,
    output logic           flush_p
);
    typedef enum logic {IDLE, WAITCRC} state_t;
    state_t         r_state, w_state;
    logic [NLT-1:0] r_txseqn, r_lastrxseqn, r_outstanding, r_flow_go, r_rxarqn;
    logic [NLT-1:0] w_txseqn, w_lastrxseqn, w_outstanding, w_flow_go, w_rxarqn;
    logic [FTW-1:0] r_flush_cnt, w_flush_cnt;
    logic [FTW:0]   w_cnt_inc;
    logic [2:0]     r_flush_lt, w_flush_lt, r_rx_lt, w_rx_lt;
    logic           r_rxpy_accept_p, r_rxpy_dup_p, r_newpy_int_p, r_flush_p;
    logic           w_hdr, w_ack, w_flush, w_crc_done, w_new, w_accept, w_dup;

    assign sendnewpy     = !r_outstanding[tx_lt_addr] & regi_txdatready & r_flow_go[tx_lt_addr] & tx_pktype_data;
    assign tx_seqn       = r_txseqn[tx_lt_addr];
    assign tx_arqn       = r_rxarqn[tx_lt_addr];
    assign tx_flow       = regi_aclrxbufempty;
    assign rxpy_accept_p = r_rxpy_accept_p;
    assign rxpy_dup_p    = r_rxpy_dup_p;
    assign newpy_int_p   = r_newpy_int_p;
    assign flush_p       = r_flush_p;

    assign w_hdr      = dec_hdr_endp & dec_hecgood & connsactive;
    assign w_ack      = w_hdr & dec_arqn & r_outstanding[dec_lt_addr];
    assign w_cnt_inc  = {1'b0, r_flush_cnt} + 1'b1;
    // an ACK landing on the flush slot beats the timeout
    assign w_flush    = ms_tslot_p & r_outstanding[r_flush_lt] & (w_cnt_inc == {1'b0, regi_flushto})
                        & !(w_ack & (dec_lt_addr == r_flush_lt));
    assign w_crc_done = (r_state == WAITCRC) & dec_crc_endp & connsactive & !dec_hdr_endp;
    assign w_new      = dec_seqn != r_lastrxseqn[r_rx_lt];
    assign w_accept   = w_crc_done & dec_crcgood & w_new & regi_aclrxbufempty;
    assign w_dup      = w_crc_done & dec_crcgood & !w_new;

    always_comb begin
        w_state      = r_state;
        w_rx_lt      = r_rx_lt;
        w_txseqn     = r_txseqn;
        w_lastrxseqn = r_lastrxseqn;
        w_outstanding = r_outstanding;
        w_flow_go    = r_flow_go;
        w_rxarqn     = r_rxarqn;
        w_flush_cnt  = r_flush_cnt;
        w_flush_lt   = r_flush_lt;
        if (ms_tslot_p & r_outstanding[r_flush_lt] & (regi_flushto != '0) & (r_flush_cnt != '1))
            w_flush_cnt = w_cnt_inc[FTW-1:0];
        if (tx_packet_st_p) begin
            w_rxarqn[tx_lt_addr] = 1'b0;
            if (sendnewpy) begin
                w_outstanding[tx_lt_addr] = 1'b1;
                w_flush_lt  = tx_lt_addr;
                w_flush_cnt = '0;
            end
        end
        if (w_hdr)
            w_flow_go[dec_lt_addr] = dec_flow;
        if (w_ack) begin
            w_outstanding[dec_lt_addr] = 1'b0;
            w_txseqn[dec_lt_addr] = !r_txseqn[dec_lt_addr];
            w_flush_cnt = (dec_lt_addr == r_flush_lt) ? '0 : w_flush_cnt;
        end
        if (w_flush) begin
            w_outstanding[r_flush_lt] = 1'b0;
            w_txseqn[r_flush_lt] = !r_txseqn[r_flush_lt];
            w_flush_cnt = '0;
        end
        if (!connsactive)
            w_state = IDLE;
        else if (r_state == IDLE) begin
            if (w_hdr & pktype_data) begin
                w_state = WAITCRC;
                w_rx_lt = dec_lt_addr;
            end
        end else if (dec_hdr_endp | dec_crc_endp)
            w_state = IDLE;
        if (w_crc_done) begin
            w_rxarqn[r_rx_lt] = dec_crcgood & (!w_new | regi_aclrxbufempty);
            w_lastrxseqn[r_rx_lt] = w_accept ? dec_seqn : r_lastrxseqn[r_rx_lt];
        end
        if (regi_ltinit_p) begin
            w_txseqn[regi_ltsel]      = 1'b1;
            w_lastrxseqn[regi_ltsel]  = 1'b0;
            w_outstanding[regi_ltsel] = 1'b0;
            w_flow_go[regi_ltsel]     = 1'b1;
            w_rxarqn[regi_ltsel]      = 1'b0;
        end
    end

    always_ff @(posedge clk_6M or negedge rstz) begin
        if (!rstz) begin
            r_state         <= IDLE;
            r_rx_lt         <= '0;
            r_txseqn        <= '1;
            r_lastrxseqn    <= '0;
            r_outstanding   <= '0;
            r_flow_go       <= '1;
            r_rxarqn        <= '0;
            r_flush_cnt     <= '0;
            r_flush_lt      <= '0;
            r_rxpy_accept_p <= 1'b0;
            r_rxpy_dup_p    <= 1'b0;
            r_newpy_int_p   <= 1'b0;
            r_flush_p       <= 1'b0;
        end else begin
            r_state         <= w_state;
            r_rx_lt         <= w_rx_lt;
            r_txseqn        <= w_txseqn;
            r_lastrxseqn    <= w_lastrxseqn;
            r_outstanding   <= w_outstanding;
            r_flow_go       <= w_flow_go;
            r_rxarqn        <= w_rxarqn;
            r_flush_cnt     <= w_flush_cnt;
            r_flush_lt      <= w_flush_lt;
            r_rxpy_accept_p <= w_accept;
            r_rxpy_dup_p    <= w_dup;
            r_newpy_int_p   <= w_ack;
            r_flush_p       <= w_flush;
        end
    end
endmodule
